// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and the
// latched request record that drives the backing-memory port.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_s;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick: first requester at or after ptr_i,
// wrapping, as a one-hot grant plus binary index.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan N positions starting at the pointer; the first hit wins.
   always_comb begin
      int   j;
      logic hit_s;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      hit_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         j        = int'(ptr_i) + i;
         j        = (j >= N) ? (j - N) : j;
         hit_s    = !any_o && req_i[j];
         gnt_o[j] = hit_s;
         idx_o    = hit_s ? IW'(j) : idx_o;
         any_o    = any_o | hit_s;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between N requesters with
// round-robin fairness, a bounded burst lock and a response timeout.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_MASTERS = 3,
   parameter int MAX_BURST = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_MASTERS-1:0]    m_req,
   input  logic [N_MASTERS-1:0]    m_lock,
   input  logic [N_MASTERS-1:0]    m_we,
   input  logic [4*N_MASTERS-1:0]  m_be,
   input  logic [32*N_MASTERS-1:0] m_addr,
   input  logic [32*N_MASTERS-1:0] m_wdata,
   output logic [N_MASTERS-1:0]    m_gnt,
   output logic [N_MASTERS-1:0]    m_rvalid,
   output logic [31:0]             m_rdata,
   output logic                    m_fault,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [3:0]              mem_be,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata,
   input  logic                    mem_rvalid,
   input  logic                    mem_fault,
   output logic                    busy,
   output logic [31:0]             stat_timeouts
);

   localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(MAX_BURST + 1);

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [LW-1:0]       lock_cnt_q, lock_cnt_d;
   logic                lock_set_q, lock_set_d;
   logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic [31:0]         stat_q, stat_d;
   mem_req_s            req_q, req_d;

   logic [N_MASTERS-1:0] rr_gnt_s, own_oh_s, win_oh_s;
   logic [IW-1:0]        rr_idx_s, win_idx_s, nxt_ptr_s;
   logic                 rr_any_s, lock_hold_s, keep_owner_s, tmo_tick_s;
   logic [LW-1:0]        cnt_next_s;

   rr_arbiter #(.N(N_MASTERS), .IW(IW)) u_rr (
      .req_i (m_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (rr_gnt_s),
      .idx_o (rr_idx_s),
      .any_o (rr_any_s)
   );

   // One-hot decode of the current owner, used for lock hold and response routing.
   always_comb begin
      own_oh_s = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         own_oh_s[i] = (owner_q == IW'(i));
      end
   end

   assign lock_hold_s  = lock_set_q && (lock_cnt_q < LW'(MAX_BURST));
   assign keep_owner_s = lock_hold_s && (|(m_req & own_oh_s));
   assign win_oh_s     = keep_owner_s ? own_oh_s : rr_gnt_s;
   assign win_idx_s    = keep_owner_s ? owner_q : rr_idx_s;
   assign nxt_ptr_s    = (win_idx_s == IW'(N_MASTERS - 1)) ? IW'(0) : (win_idx_s + IW'(1));
   assign tmo_tick_s   = (tmo_cnt_q == TW'(TIMEOUT - 1));
   assign cnt_next_s   = keep_owner_s ? (lock_cnt_q + LW'(1)) : LW'(1);

   // Next-state and combinational handshake outputs for the port FSM.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      lock_set_d = lock_set_q;
      tmo_cnt_d  = tmo_cnt_q;
      stat_d     = stat_q;
      req_d      = req_q;
      m_gnt      = '0;
      m_rvalid   = '0;
      m_rdata    = 32'h0000_0000;
      m_fault    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rr_any_s) begin
               m_gnt       = win_oh_s;
               owner_d     = win_idx_s;
               req_d.we    = m_we[win_idx_s];
               req_d.be    = m_be[int'(win_idx_s)*4 +: 4];
               req_d.addr  = m_addr[int'(win_idx_s)*32 +: 32];
               req_d.wdata = m_wdata[int'(win_idx_s)*32 +: 32];
               state_d     = ST_ISSUE;
               // A locked grant only keeps the pointer until the burst is exhausted.
               if (m_lock[win_idx_s] && (cnt_next_s < LW'(MAX_BURST))) begin
                  lock_cnt_d = cnt_next_s;
                  lock_set_d = 1'b1;
               end else begin
                  lock_cnt_d = '0;
                  lock_set_d = 1'b0;
                  rr_ptr_d   = nxt_ptr_s;
               end
            end else begin
               lock_cnt_d = '0;
               lock_set_d = 1'b0;
            end
         end
         ST_ISSUE: begin
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               m_rvalid = own_oh_s;
               m_rdata  = mem_rdata;
               m_fault  = mem_fault;
               state_d  = ST_IDLE;
               if (mem_fault) begin
                  lock_cnt_d = '0;
                  lock_set_d = 1'b0;
               end else begin
                  lock_set_d = lock_set_q;
               end
            end else if (tmo_tick_s) begin
               m_rvalid   = own_oh_s;
               m_fault    = 1'b1;
               stat_d     = (stat_q != 32'hFFFF_FFFF) ? (stat_q + 32'd1) : stat_q;
               lock_cnt_d = '0;
               lock_set_d = 1'b0;
               tmo_cnt_d  = '0;
               state_d    = ST_DRAIN;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ST_DRAIN: begin
            if (mem_rvalid || tmo_tick_s) begin
               state_d = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         lock_set_q <= 1'b0;
         tmo_cnt_q  <= '0;
         stat_q     <= 32'h0000_0000;
         req_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         lock_set_q <= lock_set_d;
         tmo_cnt_q  <= tmo_cnt_d;
         stat_q     <= stat_d;
         req_q      <= req_d;
      end
   end

   assign mem_req       = (state_q == ST_ISSUE);
   assign mem_we        = req_q.we;
   assign mem_be        = req_q.be;
   assign mem_addr      = req_q.addr;
   assign mem_wdata     = req_q.wdata;
   assign busy          = (state_q != ST_IDLE);
   assign stat_timeouts = stat_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: behavioural masters and memory,
// with grant-order and response scoreboards.
module tb_mem_port_arbiter;

   localparam logic [31:0] DATA_KEY = 32'hDEAD_AEEF;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        fault;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic [2:0]  m_req, m_lock, m_we;
   logic [11:0] m_be;
   logic [95:0] m_addr, m_wdata;
   logic [2:0]  m_gnt, m_rvalid;
   logic [31:0] m_rdata;
   logic        m_fault;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rvalid, mem_fault;
   logic        busy;
   logic [31:0] stat_timeouts;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          remaining [3];
   bit          lock_en [3];
   bit          we_m [3];
   logic [3:0]  be_m [3];
   logic [31:0] addr_m [3];
   logic [31:0] wdata_m [3];
   int          mem_lat;
   int          mem_cd;
   bit          fault_cfg;
   bit          force_rvalid;
   logic [31:0] mem_addr_lat;
   int          exp_gnt_q [$];
   rsp_t        exp_rsp_q [$];

   mem_port_arbiter #(.N_MASTERS(3), .MAX_BURST(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_lock(m_lock), .m_we(m_we), .m_be(m_be),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_fault(m_fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .mem_fault(mem_fault), .busy(busy), .stat_timeouts(stat_timeouts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle: drive masters and memory at negedge, then observe and score.
   task automatic step();
      rsp_t r;
      int   e;
      int   gi;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      mem_fault  = 1'b0;
      if (force_rvalid) begin
         mem_rvalid   = 1'b1;
         mem_rdata    = 32'hBAD0_0BAD;
         force_rvalid = 1'b0;
      end else if (mem_cd == 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_addr_lat ^ DATA_KEY;
         mem_fault  = fault_cfg;
         mem_cd     = -1;
      end else if (mem_cd > 0) begin
         mem_cd--;
      end
      for (int i = 0; i < 3; i++) begin
         m_req[i]            = (remaining[i] > 0);
         m_lock[i]           = lock_en[i];
         m_we[i]             = we_m[i];
         m_be[i*4 +: 4]      = be_m[i];
         m_addr[i*32 +: 32]  = addr_m[i];
         m_wdata[i*32 +: 32] = wdata_m[i];
      end
      #1;
      cyc++;
      if (mem_req === 1'b1) begin
         mem_addr_lat = mem_addr;
         if (mem_lat > 0) mem_cd = mem_lat - 1;
      end
      if (m_gnt !== 3'b000) begin
         gi = 0;
         for (int i = 0; i < 3; i++) if (m_gnt[i]) gi = i;
         if (exp_gnt_q.size() > 0) begin
            e = exp_gnt_q.pop_front();
            total++;
            if (m_gnt !== (3'b001 << e)) begin
               bad++;
               $display("FAIL gnt_order: got gnt=%b want master %0d", m_gnt, e);
            end
         end
         r.idx   = gi;
         r.fault = (mem_lat <= 0) ? 1'b1 : fault_cfg;
         r.data  = (mem_lat <= 0) ? 32'h0 : (addr_m[gi] ^ DATA_KEY);
         exp_rsp_q.push_back(r);
         remaining[gi]--;
         addr_m[gi] = addr_m[gi] + 32'd1;
      end
      if (m_rvalid !== 3'b000) begin
         total++;
         if (exp_rsp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_rvalid: got rvalid=%b want none", m_rvalid);
         end else begin
            r = exp_rsp_q.pop_front();
            if (m_rvalid !== (3'b001 << r.idx) || m_rdata !== r.data || m_fault !== r.fault) begin
               bad++;
               $display("FAIL response: got rvalid=%b rdata=%h fault=%b want master %0d rdata=%h fault=%b",
                        m_rvalid, m_rdata, m_fault, r.idx, r.data, r.fault);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         remaining[i] = 0;
         lock_en[i]   = 1'b0;
         we_m[i]      = 1'b0;
         be_m[i]      = 4'hF;
         wdata_m[i]   = 32'h0;
      end
      mem_lat      = 1;
      mem_cd       = -1;
      fault_cfg    = 1'b0;
      force_rvalid = 1'b0;
      step();
      step();
      rst = 1'b0;
      exp_gnt_q.delete();
      exp_rsp_q.delete();
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         step();
         if (remaining[0] == 0 && remaining[1] == 0 && remaining[2] == 0 &&
             exp_rsp_q.size() == 0 && busy === 1'b0) done = 1'b1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s_complete: got pending_rsp=%0d busy=%b want 0 and 0", name, exp_rsp_q.size(), busy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      step();
      total++;
      if (busy !== 1'b0 || m_gnt !== 3'b000 || m_rvalid !== 3'b000) begin
         bad++;
         $display("FAIL reset_ctrl: got busy=%b gnt=%b rvalid=%b want 0", busy, m_gnt, m_rvalid);
      end
      total++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_mem: got req=%b we=%b be=%h addr=%h wdata=%h want 0",
                  mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
      total++;
      if (stat_timeouts !== 32'h0 || m_rdata !== 32'h0 || m_fault !== 1'b0) begin
         bad++;
         $display("FAIL reset_stat: got stat=%0d rdata=%h fault=%b want 0", stat_timeouts, m_rdata, m_fault);
      end
   endtask

   task automatic test_single_read();
      bit found = 1'b0;
      int t_req;
      do_reset();
      addr_m[1]    = 32'h0000_1000;
      remaining[1] = 1;
      mem_lat      = 3;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (m_gnt === 3'b010) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL single_gnt: got no gnt[1] want gnt=010"); end
      step();
      t_req = cyc;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL single_issue: got req=%b addr=%h we=%b want 1 00001000 0", mem_req, mem_addr, mem_we);
      end
      step();
      total++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0000_1000) begin
         bad++;
         $display("FAIL single_pulse: got req=%b addr=%h want 0 00001000", mem_req, mem_addr);
      end
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (m_rvalid !== 3'b000) found = 1'b1;
      end
      total++;
      if (!found || (cyc - t_req) != 3 || m_rdata !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL single_latency: got %0d cycles rdata=%h want 3 deadbeef", cyc - t_req, m_rdata);
      end
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
   endtask

   task automatic test_fairness();
      int prev = -1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         remaining[i] = 2;
         addr_m[i]    = 32'h0000_0100 * (i + 1);
      end
      for (int n = 0; n < 6; n++) exp_gnt_q.push_back(n % 3);
      for (int k = 0; k < 60 && exp_rsp_q.size() + remaining[0] + remaining[1] + remaining[2] > 0; k++) begin
         step();
         if (m_gnt !== 3'b000) begin
            if (prev >= 0) begin
               total++;
               if ((cyc - prev) != 3) begin
                  bad++;
                  $display("FAIL fair_spacing: got %0d cycles want 3", cyc - prev);
               end
            end
            prev = cyc;
         end
      end
      wait_idle("fair");
      total++;
      if (exp_gnt_q.size() != 0) begin bad++; $display("FAIL fair_count: got %0d missing want 0", exp_gnt_q.size()); end
   endtask

   task automatic test_burst_lock();
      bit found = 1'b0;
      do_reset();
      addr_m[0]    = 32'h0000_0400;
      addr_m[1]    = 32'h0000_0800;
      lock_en[1]   = 1'b1;
      remaining[1] = 10;
      for (int n = 0; n < 8; n++) exp_gnt_q.push_back(1);
      exp_gnt_q.push_back(0);
      exp_gnt_q.push_back(1);
      exp_gnt_q.push_back(1);
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (m_gnt !== 3'b000) found = 1'b1;
      end
      remaining[0] = 1;
      wait_idle("burst");
      total++;
      if (exp_gnt_q.size() != 0) begin bad++; $display("FAIL burst_count: got %0d missing want 0", exp_gnt_q.size()); end
   endtask

   task automatic test_timeout();
      bit found = 1'b0;
      int t_req = 0;
      do_reset();
      addr_m[0]    = 32'h0000_0C00;
      mem_lat      = -1;
      remaining[0] = 1;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (mem_req === 1'b1) begin found = 1'b1; t_req = cyc; end
      end
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         step();
         if (m_rvalid !== 3'b000) found = 1'b1;
      end
      total++;
      if (!found || (cyc - t_req) != 4 || m_fault !== 1'b1) begin
         bad++;
         $display("FAIL tmo_latency: got %0d cycles fault=%b want 4 1", cyc - t_req, m_fault);
      end
      step();
      total++;
      if (stat_timeouts !== 32'd1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL tmo_stat: got stat=%0d busy=%b want 1 1", stat_timeouts, busy);
      end
      force_rvalid = 1'b1;
      step();
      total++;
      if (m_rvalid !== 3'b000) begin bad++; $display("FAIL drain_discard: got rvalid=%b want 000", m_rvalid); end
      step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL drain_exit: got busy=%b want 0", busy); end
      mem_lat      = 1;
      addr_m[2]    = 32'h0000_0D00;
      remaining[2] = 1;
      wait_idle("post_drain");
      mem_lat      = 4;
      remaining[0] = 1;
      wait_idle("tmo_edge");
      total++;
      if (stat_timeouts !== 32'd1) begin bad++; $display("FAIL tmo_edge_stat: got %0d want 1", stat_timeouts); end
   endtask

   task automatic test_write_fault();
      bit found = 1'b0;
      do_reset();
      addr_m[2]    = 32'h0000_2000;
      we_m[2]      = 1'b1;
      be_m[2]      = 4'h3;
      wdata_m[2]   = 32'h1234_5678;
      lock_en[2]   = 1'b1;
      fault_cfg    = 1'b1;
      mem_lat      = 3;
      remaining[2] = 1;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (mem_req === 1'b1) found = 1'b1;
      end
      for (int n = 0; n < 3; n++) begin
         total++;
         if (mem_we !== 1'b1 || mem_be !== 4'h3 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h0000_2000) begin
            bad++;
            $display("FAIL write_hold%0d: got we=%b be=%h wdata=%h addr=%h want 1 3 12345678 00002000",
                     n, mem_we, mem_be, mem_wdata, mem_addr);
         end
         step();
      end
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         if (m_rvalid !== 3'b000) found = 1'b1;
         else step();
      end
      fault_cfg    = 1'b0;
      mem_lat      = 1;
      we_m[2]      = 1'b0;
      remaining[0] = 1;
      remaining[2] = 1;
      exp_gnt_q.push_back(0);
      exp_gnt_q.push_back(2);
      wait_idle("fault_unlock");
      total++;
      if (exp_gnt_q.size() != 0) begin bad++; $display("FAIL fault_unlock_count: got %0d missing want 0", exp_gnt_q.size()); end
   endtask

   task automatic test_reset_in_wait();
      bit found = 1'b0;
      do_reset();
      addr_m[1]    = 32'h0000_3000;
      mem_lat      = -1;
      remaining[1] = 1;
      for (int k = 0; k < 10 && !found; k++) begin
         step();
         if (mem_req === 1'b1) found = 1'b1;
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_rsp_q.delete();
      force_rvalid = 1'b1;
      step();
      total++;
      if (m_rvalid !== 3'b000 || busy !== 1'b0 || mem_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_wait_ignore: got rvalid=%b busy=%b req=%b want 000 0 0", m_rvalid, busy, mem_req);
      end
      total++;
      if (mem_addr !== 32'h0 || mem_be !== 4'h0) begin
         bad++;
         $display("FAIL rst_wait_mem: got addr=%h be=%h want 0 0", mem_addr, mem_be);
      end
      mem_lat      = 1;
      remaining[0] = 1;
      remaining[2] = 1;
      exp_gnt_q.push_back(0);
      exp_gnt_q.push_back(2);
      wait_idle("rst_ptr");
      total++;
      if (exp_gnt_q.size() != 0) begin bad++; $display("FAIL rst_ptr_count: got %0d missing want 0", exp_gnt_q.size()); end
   endtask

   initial begin
      rst        = 1'b1;
      m_req      = 3'b000;
      m_lock     = 3'b000;
      m_we       = 3'b000;
      m_be       = 12'h000;
      m_addr     = 96'h0;
      m_wdata    = 96'h0;
      mem_rdata  = 32'h0;
      mem_rvalid = 1'b0;
      mem_fault  = 1'b0;
      mem_addr_lat = 32'h0;
      for (int i = 0; i < 3; i++) addr_m[i] = 32'h0;
      test_reset();
      test_single_read();
      test_fairness();
      test_burst_lock();
      test_timeout();
      test_write_fault();
      test_reset_in_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
